// File: rtl/fetch_pkg.sv
// Shared types and constants for the Argon instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Single-word Wishbone read bus between the fetch master and the instruction ROM.
interface wishbone_if;
  import fetch_pkg::*;

  logic [31:0]            address;
  logic                   cycle;
  logic                   strobe;
  logic                   ack;
  logic [INSTR_WIDTH-1:0] data_out;

  modport master (
    output address, cycle, strobe,
    input  ack, data_out
  );

  modport slave (
    input  address, cycle, strobe,
    output ack, data_out
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of {pc, instr} entries; flush empties it and wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only alongside a pop of the same slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Argon fetch stage: PC register, single-outstanding Wishbone read master and
// instruction buffer. Decode handshake: an entry transfers on any clock edge where
// instr_valid && instr_ready are both high; instr_pc/instr_data hold while valid && !ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  wishbone_if.master   wishbone,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr_data,
  output logic [31:0]  instr_pc,
  output fetch_state_t dbg_state_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state_q;
  logic [31:0]   pc_q;
  logic [31:0]   address_q;
  logic          cycle_q;
  logic          strobe_q;

  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_push_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW:0]   count_after_push;
  logic          room_after_push;
  logic [31:0]   pc_inc;
  logic          bus_ack;

  assign bus_ack        = wishbone.ack;
  assign pc_inc         = pc_q + PC_STEP;
  assign fifo_pop       = instr_valid && instr_ready;
  assign fifo_push      = (state_q == REQ) && bus_ack && !redirect_valid;
  assign fifo_push_data = '{pc: pc_q, instr: wishbone.data_out};

  // Occupancy after this edge's push and pop decides whether the next read may start.
  assign count_after_push = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(fifo_pop);
  assign room_after_push  = count_after_push < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      address_q <= RESET_PC;
      cycle_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      if (redirect_valid) pc_q <= align_pc(redirect_pc);
      case (state_q)
        IDLE: begin
          if (!redirect_valid && !fifo_full) begin
            state_q   <= REQ;
            address_q <= pc_q;
            cycle_q   <= 1'b1;
            strobe_q  <= 1'b1;
          end
        end
        REQ: begin
          if (bus_ack && !redirect_valid) begin
            pc_q <= pc_inc;
            if (room_after_push) begin
              address_q <= pc_inc;
            end else begin
              state_q  <= IDLE;
              cycle_q  <= 1'b0;
              strobe_q <= 1'b0;
            end
          end else if (bus_ack) begin
            state_q  <= IDLE;
            cycle_q  <= 1'b0;
            strobe_q <= 1'b0;
          end else if (redirect_valid) begin
            // The slave finishes regardless, so ride out the stale read.
            state_q <= DISCARD;
          end
        end
        DISCARD: begin
          if (bus_ack) begin
            state_q  <= IDLE;
            cycle_q  <= 1'b0;
            strobe_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          cycle_q  <= 1'b0;
          strobe_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign wishbone.address = address_q;
  assign wishbone.cycle   = cycle_q;
  assign wishbone.strobe  = strobe_q;

  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM slave model, directed scenarios, random ready/redirect traffic.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic         clk;
  logic         reset;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr_data;
  logic [31:0]  instr_pc;
  fetch_state_t dbg_state;

  wishbone_if wb ();

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .wishbone       (wb),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got time %0t required < 500000", $time);
    $fatal(1, "timeout");
  end

  // ---------------- ROM contents and slave ----------------
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h11;
      32'h4: return 32'h22;
      32'h8: return 32'h33;
      default: return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  logic [1:0] slv_wait;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb.ack      <= 1'b0;
      wb.data_out <= '0;
      slv_wait    <= 2'd0;
    end else if (wb.ack) begin
      wb.ack   <= 1'b0;
      slv_wait <= 2'd0;
    end else if (wb.cycle && wb.strobe) begin
      if (slv_wait == 2'd1) begin
        wb.ack      <= 1'b1;
        wb.data_out <= rom_word(wb.address);
      end else begin
        slv_wait <= slv_wait + 2'd1;
      end
    end
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the delivered stream is consecutive words from the last
  // restart point (reset or redirect target), each paired with its ROM word.
  logic [63:0] exp_q[$];
  logic [31:0] gen_pc;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({gen_pc, rom_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_model(input logic [31:0] start);
    exp_q.delete();
    gen_pc = {start[31:2], 2'b00};
    refill();
  endtask

  int          del_cyc[$];
  logic [31:0] del_pc_q[$];
  logic [31:0] ack_addr_q[$];
  int          ack_cnt = 0;

  // Decode-side monitor: a transfer happens at the coming edge unless flushed.
  logic        stall_prev = 1'b0;
  logic [63:0] stall_entry;
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_hold", {63'd0, instr_valid}, 64'd1);
        check("stall_entry_hold", {instr_pc, instr_data}, stall_entry);
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        refill();
        exp = exp_q.pop_front();
        check("deliver_pc", {32'd0, instr_pc}, {32'd0, exp[63:32]});
        check("deliver_data", {32'd0, instr_data}, {32'd0, exp[31:0]});
        del_cyc.push_back(cyc_cnt);
        del_pc_q.push_back(instr_pc);
      end
      stall_prev  = instr_valid && !instr_ready && !redirect_valid;
      stall_entry = {instr_pc, instr_data};
    end
  end

  // Bus monitor: address stable until ack, never held on the same address past ack.
  logic        bus_stb_prev = 1'b0;
  logic        bus_ack_prev = 1'b0;
  logic [31:0] bus_addr_prev;
  always @(negedge clk) begin
    if (!reset) begin
      bus_stb_prev = 1'b0;
      bus_ack_prev = 1'b0;
    end else begin
      if (bus_stb_prev && !bus_ack_prev)
        check("addr_stable_until_ack", {31'd0, wb.strobe, wb.address}, {31'd0, 1'b1, bus_addr_prev});
      if (bus_stb_prev && bus_ack_prev)
        check("no_hold_past_ack", {63'd0, (wb.strobe && wb.address == bus_addr_prev)}, 64'd0);
      if (wb.ack && wb.cycle && wb.strobe) begin
        ack_cnt++;
        ack_addr_q.push_back(wb.address);
      end
      bus_stb_prev  = wb.cycle && wb.strobe;
      bus_ack_prev  = wb.ack;
      bus_addr_prev = wb.address;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    cyc(2);
    @(negedge clk);
    check("rst_cyc_stb", {62'd0, wb.cycle, wb.strobe}, 64'd0);
    check("rst_address", {32'd0, wb.address}, {32'd0, RESET_PC});
    check("rst_instr", {31'd0, instr_valid, instr_pc}, 64'd0);
    check("rst_data", {32'd0, instr_data}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
    restart_model(RESET_PC);
    del_cyc.delete();
    del_pc_q.delete();
    ack_addr_q.delete();
    ack_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_pc    = target;
    redirect_valid = 1'b1;
    restart_model(target);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  // Waits at negedges for a live request; returns its address, or flags a timeout.
  task automatic wait_req(input string name, input logic [31:0] not_addr, input logic use_not,
                          output logic [31:0] addr);
    logic found;
    found = 1'b0;
    addr  = 32'hDEAD_BEEF;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (wb.strobe && dbg_state == REQ && !(use_not && wb.address == not_addr)) begin
        found = 1'b1;
        addr  = wb.address;
      end
    end
    if (!found) check(name, 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    logic        found;
    logic [31:0] a;

    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;

    // 1: streaming from reset
    do_reset();
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) check("strobe_first_edge", {62'd0, wb.cycle, wb.strobe}, 64'd3);
      if (instr_valid) begin
        found = 1'b1;
        n = i;
      end
    end
    check("first_valid_latency", 64'(n), 64'd4);
    cyc(10);
    check("t1_deliveries", {63'd0, del_cyc.size() >= 3}, 64'd1);
    if (del_cyc.size() >= 3) begin
      check("t1_spacing_a", 64'(del_cyc[1] - del_cyc[0]), 64'd3);
      check("t1_spacing_b", 64'(del_cyc[2] - del_cyc[1]), 64'd3);
      check("t1_pcs", {32'd0, del_pc_q[2]}, 64'h8);
    end

    // 2: decode stalled from the start
    instr_ready = 1'b0;
    do_reset();
    cyc(15);
    @(negedge clk);
    check("t2_read_count", 64'(ack_cnt), 64'd2);
    check("t2_bus_idle", {62'd0, wb.cycle, wb.strobe}, 64'd0);
    check("t2_state", {62'd0, dbg_state}, {62'd0, IDLE});
    check("t2_head", {31'd0, instr_valid, instr_pc}, {31'd0, 1'b1, 32'h0});
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    cyc(20);
    check("t2_resume_addr", {32'd0, (ack_addr_q.size() >= 3) ? ack_addr_q[2] : 32'hDEAD_BEEF}, 64'h8);
    check("t2_second_pc", {32'd0, (del_pc_q.size() >= 2) ? del_pc_q[1] : 32'hDEAD_BEEF}, 64'h4);

    // 3: redirect while the first read is outstanding
    instr_ready = 1'b1;
    do_reset();
    cyc(1);
    do_redirect(32'h100);
    cyc(15);
    check("t3_stale_addr", {32'd0, (ack_addr_q.size() >= 2) ? ack_addr_q[0] : 32'hDEAD_BEEF}, 64'h0);
    check("t3_next_addr", {32'd0, (ack_addr_q.size() >= 2) ? ack_addr_q[1] : 32'hDEAD_BEEF}, 64'h100);
    check("t3_first_pc", {32'd0, (del_pc_q.size() >= 1) ? del_pc_q[0] : 32'hDEAD_BEEF}, 64'h100);

    // 4: redirect coinciding with an ack while the buffer holds entries
    instr_ready = 1'b0;
    do_reset();
    cyc(12);
    instr_ready = 1'b1;
    cyc(1);
    instr_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (wb.ack && wb.strobe && wb.address == 32'h8) found = 1'b1;
    end
    check("t4_ack8_seen", {63'd0, found}, 64'd1);
    do_redirect(32'h200);
    @(negedge clk);
    check("t4_flushed", {63'd0, instr_valid}, 64'd0);
    check("t4_idle", {61'd0, dbg_state, wb.strobe}, {61'd0, IDLE, 1'b0});
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    cyc(15);
    check("t4_first_pc", {32'd0, (del_pc_q.size() >= 2) ? del_pc_q[0] : 32'hDEAD_BEEF}, 64'h0);
    check("t4_after_redirect", {32'd0, (del_pc_q.size() >= 2) ? del_pc_q[1] : 32'hDEAD_BEEF}, 64'h200);

    // 5: alignment of redirect target and PC wrap
    instr_ready = 1'b1;
    cyc($urandom_range(0, 5));
    do_redirect(32'h203);
    wait_req("t5_req_timeout", 32'h0, 1'b0, a);
    check("t5_aligned_addr", {32'd0, a}, 64'h200);
    cyc(1);
    do_redirect(32'hFFFF_FFFC);
    wait_req("t5_req_timeout", 32'h0, 1'b0, a);
    check("t5_top_addr", {32'd0, a}, 64'hFFFF_FFFC);
    wait_req("t5_req_timeout", 32'hFFFF_FFFC, 1'b1, a);
    check("t5_wrap_addr", {32'd0, a}, 64'h0);
    cyc(10);

    // 6: asynchronous reset in the middle of a read
    instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      #1;
      if (wb.strobe && instr_valid) found = 1'b1;
    end
    check("t6_busy_seen", {63'd0, found}, 64'd1);
    reset = 1'b0;
    #1;
    check("t6_async_clear", {61'd0, wb.cycle, wb.strobe, instr_valid}, 64'd0);
    check("t6_async_state", {62'd0, dbg_state}, {62'd0, IDLE});
    do_reset();
    instr_ready = 1'b1;
    cyc(12);
    check("t6_restart_addr", {32'd0, (ack_addr_q.size() >= 1) ? ack_addr_q[0] : 32'hDEAD_BEEF}, {32'd0, RESET_PC});
    check("t6_restart_pc", {32'd0, (del_pc_q.size() >= 1) ? del_pc_q[0] : 32'hDEAD_BEEF}, {32'd0, RESET_PC});

    // 7: random decode back-pressure and redirects
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else a = $urandom;
        do_redirect(a);
      end else begin
        cyc(1);
      end
    end
    instr_ready = 1'b1;
    cyc(20);
    check("t7_traffic", {63'd0, del_pc_q.size() > 100}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
